// File: rtl/led_port_ctrl_pkg.sv
// Register map and mode encodings for the memory-mapped LED port.
package led_port_ctrl_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_MODE = 2'd1,
    ADDR_DUTY = 2'd2,
    ADDR_RATE = 2'd3
  } addr_e;

  typedef enum logic [1:0] {
    MODE_DIRECT  = 2'd0,
    MODE_BLINK   = 2'd1,
    MODE_PWM     = 2'd2,
    MODE_MARQUEE = 2'd3
  } mode_e;

endpackage

// File: rtl/led_port_ctrl_tick_gen.sv
// Prescaler plus programmable step divider; o_step pulses on the tick that reaches i_rate.
// Combinational outputs from registered counters, no backpressure.
module led_port_ctrl_tick_gen #(
  parameter int PRESCALE  = 4,
  parameter int RATE_BITS = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_clr_stp,
  input  logic [RATE_BITS-1:0] i_rate,
  output logic                 o_step
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0]        r_pre;
  logic [RATE_BITS-1:0] r_stp;
  logic                 w_tick;

  assign w_tick = (r_pre == PRE_LAST);
  assign o_step = w_tick && (r_stp == i_rate);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pre <= '0;
      r_stp <= '0;
    end else begin
      if (i_clr || w_tick) r_pre <= '0;
      else                 r_pre <= r_pre + 1'b1;

      if (i_clr || i_clr_stp) r_stp <= '0;
      else if (o_step)        r_stp <= '0;
      else if (w_tick)        r_stp <= r_stp + 1'b1;
    end
  end

endmodule

// File: rtl/led_port_ctrl.sv
// Memory-mapped LED port: direct / blink / PWM / marquee modes behind a 4-entry register file.
// Write-to-led 2 edges, read data 1 edge after rd_en; always ready, no backpressure.
module led_port_ctrl
  import led_port_ctrl_pkg::*;
#(
  parameter int N_LED     = 8,
  parameter int PRESCALE  = 4,
  parameter int PWM_BITS  = 4,
  parameter int RATE_BITS = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic             i_rd_en,
  input  logic [1:0]       i_addr,
  input  logic [N_LED-1:0] i_wr_data,
  output logic [N_LED-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic [N_LED-1:0] o_led
);

  logic [N_LED-1:0]     r_data;
  mode_e                r_mode;
  logic [PWM_BITS-1:0]  r_duty;
  logic [RATE_BITS-1:0] r_rate;
  logic [PWM_BITS-1:0]  r_pwm;
  logic                 r_phase;
  logic [N_LED-1:0]     r_rot;
  logic [N_LED-1:0]     r_led;
  logic [N_LED-1:0]     r_rd_data;
  logic                 r_rd_vld;

  logic                 w_wr_data, w_wr_mode, w_wr_duty, w_wr_rate;
  logic                 w_step;
  logic [N_LED-1:0]     w_led_nxt;
  logic [N_LED-1:0]     w_rd_mux;

  assign w_wr_data = i_wr_en && (i_addr == ADDR_DATA);
  assign w_wr_mode = i_wr_en && (i_addr == ADDR_MODE);
  assign w_wr_duty = i_wr_en && (i_addr == ADDR_DUTY);
  assign w_wr_rate = i_wr_en && (i_addr == ADDR_RATE);

  led_port_ctrl_tick_gen #(
    .PRESCALE  (PRESCALE),
    .RATE_BITS (RATE_BITS)
  ) u_tick_gen (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (w_wr_mode),
    .i_clr_stp (w_wr_rate),
    .i_rate    (r_rate),
    .o_step    (w_step)
  );

  always_comb begin
    w_led_nxt = r_data;
    case (r_mode)
      MODE_DIRECT:  w_led_nxt = r_data;
      MODE_BLINK:   w_led_nxt = r_data & {N_LED{r_phase}};
      MODE_PWM:     w_led_nxt = r_data & {N_LED{r_pwm < r_duty}};
      MODE_MARQUEE: w_led_nxt = r_rot;
      default:      w_led_nxt = r_data;
    endcase
  end

  // Read mux sees pre-write values, so a same-cycle write/read returns the old contents.
  always_comb begin
    w_rd_mux = r_data;
    case (i_addr)
      ADDR_DATA: w_rd_mux = r_data;
      ADDR_MODE: w_rd_mux = N_LED'(r_mode);
      ADDR_DUTY: w_rd_mux = N_LED'(r_duty);
      ADDR_RATE: w_rd_mux = N_LED'(r_rate);
      default:   w_rd_mux = r_data;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data    <= '0;
      r_mode    <= MODE_DIRECT;
      r_duty    <= '0;
      r_rate    <= '0;
      r_pwm     <= '0;
      r_phase   <= 1'b0;
      r_rot     <= '0;
      r_led     <= '0;
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
    end else begin
      if (w_wr_data) r_data <= i_wr_data;
      if (w_wr_mode) r_mode <= mode_e'(i_wr_data[1:0]);
      if (w_wr_duty) r_duty <= PWM_BITS'(i_wr_data);
      if (w_wr_rate) r_rate <= RATE_BITS'(i_wr_data);

      if (w_wr_mode) begin
        r_pwm   <= '0;
        r_phase <= 1'b0;
      end else begin
        r_pwm <= r_pwm + 1'b1;
        if (w_step) r_phase <= ~r_phase;
      end

      // A DATA rewrite in marquee reloads the pattern and wins over a coincident step.
      if (w_wr_mode)
        r_rot <= r_data;
      else if (w_wr_data && (r_mode == MODE_MARQUEE))
        r_rot <= i_wr_data;
      else if (w_step && (r_mode == MODE_MARQUEE))
        r_rot <= (r_rot << 1) | (r_rot >> (N_LED - 1));

      r_led    <= w_led_nxt;
      r_rd_vld <= i_rd_en;
      if (i_rd_en) r_rd_data <= w_rd_mux;
    end
  end

  assign o_led      = r_led;
  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_vld;

endmodule

// File: tb/tb_led_port_ctrl.sv
// Directed bench for led_port_ctrl at N_LED=8, PRESCALE=4, PWM_BITS=4, RATE_BITS=8.
module tb_led_port_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_wr_en;
  logic       i_rd_en;
  logic [1:0] i_addr;
  logic [7:0] i_wr_data;
  logic [7:0] o_rd_data;
  logic       o_rd_valid;
  logic [7:0] o_led;

  int n_vec  = 0;
  int n_miss = 0;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MODE = 2'd1;
  localparam logic [1:0] A_DUTY = 2'd2;
  localparam logic [1:0] A_RATE = 2'd3;

  led_port_ctrl #(
    .N_LED     (8),
    .PRESCALE  (4),
    .PWM_BITS  (4),
    .RATE_BITS (8)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_en    (i_wr_en),
    .i_rd_en    (i_rd_en),
    .i_addr     (i_addr),
    .i_wr_data  (i_wr_data),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid),
    .o_led      (o_led)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end 1ns after a rising edge.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    i_wr_en = 1'b1; i_addr = a; i_wr_data = d;
    @(posedge i_clk); #1;
    i_wr_en = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp, input string tag);
    i_rd_en = 1'b1; i_addr = a;
    @(posedge i_clk); #1;
    i_rd_en = 1'b0;
    chk({tag, "_dat"}, 32'(o_rd_data), 32'(exp));
    chk({tag, "_vld"}, 32'(o_rd_valid), 32'd1);
    @(posedge i_clk); #1;
    chk({tag, "_vld_drop"}, 32'(o_rd_valid), 32'd0);
  endtask

  task automatic step_clk(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  logic [7:0] mq [4] = '{8'h81, 8'h03, 8'h06, 8'h0C};
  logic [7:0] exp_led;
  int         on_cnt;

  initial begin
    i_rst_n = 1'b0; i_wr_en = 1'b0; i_rd_en = 1'b0; i_addr = 2'd0; i_wr_data = 8'h00;
    step_clk(2);
    chk("rst_led", 32'(o_led), 32'h0);
    chk("rst_rd_data", 32'(o_rd_data), 32'h0);
    chk("rst_rd_vld", 32'(o_rd_valid), 32'h0);
    @(negedge i_clk) i_rst_n = 1'b1;
    step_clk(1);

    // Mid-run async reset with a read in flight.
    wr(A_DATA, 8'hFF);
    step_clk(1);
    chk("pre_rst_led", 32'(o_led), 32'hFF);
    wr(A_MODE, 8'h00);
    i_rd_en = 1'b1; i_addr = A_DATA;
    @(posedge i_clk); #1;
    i_rd_en = 1'b0;
    chk("pre_rst_vld", 32'(o_rd_valid), 32'h1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("async_rst_led", 32'(o_led), 32'h0);
    chk("async_rst_vld", 32'(o_rd_valid), 32'h0);
    chk("async_rst_rdd", 32'(o_rd_data), 32'h0);
    @(negedge i_clk) i_rst_n = 1'b1;
    step_clk(1);
    rd(A_MODE, 8'h00, "rst_mode");
    rd(A_DATA, 8'h00, "rst_data");

    // DIRECT
    wr(A_DATA, 8'hA5);
    chk("direct_t1", 32'(o_led), 32'h00);
    step_clk(1);
    chk("direct_t2", 32'(o_led), 32'hA5);
    rd(A_DATA, 8'hA5, "rd_data");

    // BLINK, RATE=1: 8 clk off, 8 clk on, starting off
    wr(A_DATA, 8'h0F);
    wr(A_RATE, 8'h01);
    wr(A_MODE, 8'h01);
    for (int k = 1; k <= 24; k++) begin
      step_clk(1);
      exp_led = (((k - 1) / 8) % 2 == 1) ? 8'h0F : 8'h00;
      chk($sformatf("blink_%0d", k), 32'(o_led), 32'(exp_led));
    end

    // PWM, DUTY=4: on for 4 of every 16 clk
    wr(A_DATA, 8'hFF);
    wr(A_DUTY, 8'h04);
    wr(A_MODE, 8'h02);
    for (int k = 1; k <= 32; k++) begin
      step_clk(1);
      exp_led = (((k - 1) % 16) < 4) ? 8'hFF : 8'h00;
      chk($sformatf("pwm4_%0d", k), 32'(o_led), 32'(exp_led));
    end
    wr(A_DUTY, 8'h00);
    on_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      step_clk(1);
      if (o_led != 8'h00) on_cnt++;
    end
    chk("pwm0_on_cycles", 32'(on_cnt), 32'd0);

    // MARQUEE, RATE=0: one shift per 4 clk
    wr(A_RATE, 8'h00);
    wr(A_DATA, 8'h81);
    wr(A_MODE, 8'h03);
    for (int k = 1; k <= 16; k++) begin
      step_clk(1);
      chk($sformatf("mq_%0d", k), 32'(o_led), 32'(mq[(k - 1) / 4]));
    end
    step_clk(3);
    chk("mq_pre_rewrite", 32'(o_led), 32'h18);
    wr(A_DATA, 8'h01);
    step_clk(1);
    chk("mq_rewrite", 32'(o_led), 32'h01);
    step_clk(3);
    chk("mq_rewrite_hold", 32'(o_led), 32'h01);
    step_clk(1);
    chk("mq_after_rewrite", 32'(o_led), 32'h02);

    // Same-cycle write and read of DUTY returns the old value
    wr(A_DUTY, 8'h03);
    i_wr_en = 1'b1; i_rd_en = 1'b1; i_addr = A_DUTY; i_wr_data = 8'h09;
    @(posedge i_clk); #1;
    i_wr_en = 1'b0; i_rd_en = 1'b0;
    chk("coll_old", 32'(o_rd_data), 32'h03);
    chk("coll_vld", 32'(o_rd_valid), 32'h1);
    step_clk(1);
    rd(A_DUTY, 8'h09, "coll_new");
    rd(A_RATE, 8'h00, "rd_rate");
    rd(A_MODE, 8'h03, "rd_mode");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
